// File: rtl/uart_tx.sv
// UART 8N1 transmitter: pulls bytes from the read side of a FIFO and serialises
// them LSB first with one start bit and one stop bit at CLKS_PER_BIT clocks per bit.
module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH:0]   fifo_count,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  fifo_r_enable,
    output logic                  txd,
    output logic                  busy
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  txd_q, txd_d;
    logic                  rd_en_q, rd_en_d;
    logic                  busy_q, busy_d;
    logic                  bit_done;

    assign bit_done = (cnt_q == CNT_LAST);

    // cnt_d defaults to zero so every state entry and bit boundary restarts the period
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = '0;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                if (fifo_count != '0) state_d = FETCH;
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                shift_d = fifo_r_data;
                state_d = START;
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) state_d = STOP;
                    else                   bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) state_d = IDLE;
                else          cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered pins line up with it
        rd_en_d = (state_d == FETCH);
        busy_d  = (state_d != IDLE);
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
        end
    end

    assign fifo_r_enable = rd_en_q;
    assign txd           = txd_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: FIFO model feeding the DUT, a frame-decoding monitor that
// checks each received frame against a queue of written bytes, and directed plus random stimulus.
module tb_uart_tx;
    localparam int C  = 4;
    localparam int C2 = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] fifo_count = '0;
    logic [7:0] fifo_r_data = '0;
    logic       fifo_r_enable, txd, busy;

    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic [7:0] fifo_mem[$];

    logic [8:0] fc2 = '0;
    logic [7:0] d2 = '0;
    logic [7:0] b2 = '0;
    logic       wr2 = 1'b0;
    logic       rd2, txd2, busy2;

    int checks = 0, failures = 0;
    logic [7:0] exp_q[$];
    int frames_done = 0, last_gap = 0, rd_pulses = 0, writes = 0;

    uart_tx #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CLKS_PER_BIT(C)) dut (
        .CLK(clk), .RST(rst), .fifo_count(fifo_count), .fifo_r_data(fifo_r_data),
        .fifo_r_enable(fifo_r_enable), .txd(txd), .busy(busy)
    );

    uart_tx #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CLKS_PER_BIT(C2)) dut_min (
        .CLK(clk), .RST(rst), .fifo_count(fc2), .fifo_r_data(d2),
        .fifo_r_enable(rd2), .txd(txd2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // FIFO with registered read data; contents are not affected by rst
    always @(posedge clk) begin
        if (fifo_r_enable && fifo_mem.size() > 0) fifo_r_data <= fifo_mem.pop_front();
        if (wr_en) fifo_mem.push_back(wr_data);
        fifo_count <= 9'(fifo_mem.size());
    end

    always @(posedge clk) begin
        if (rd2) begin
            d2  <= b2;
            fc2 <= '0;
        end else if (wr2) begin
            fc2 <= 9'd1;
        end
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame monitor / scoreboard
    initial begin : monitor
        int   gap;
        logic s[$];
        bit   aborted, rd_seen, busy_low, stable;
        logic [9:0] got, want;
        logic [7:0] b;
        gap = 1000;
        forever begin
            @(negedge clk);
            if (rst) begin
                gap = 1000;
            end else if (txd) begin
                gap++;
            end else begin
                last_gap = gap;
                check(gap >= 3, "idle_gap", gap, 3);
                s.delete();
                s.push_back(txd);
                aborted  = 1'b0;
                rd_seen  = fifo_r_enable;
                busy_low = !busy;
                for (int n = 1; n < 10 * C; n++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    s.push_back(txd);
                    if (fifo_r_enable) rd_seen = 1'b1;
                    if (!busy) busy_low = 1'b1;
                end
                if (aborted) begin
                    if (exp_q.size() > 0) exp_q.delete(0);
                    gap = 1000;
                end else begin
                    stable = 1'b1;
                    for (int bi = 0; bi < 10; bi++) begin
                        got[bi] = s[bi * C];
                        for (int k = 0; k < C; k++)
                            if (s[bi * C + k] !== got[bi]) stable = 1'b0;
                    end
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_frame", 32'(got), 0);
                    end else begin
                        b    = exp_q.pop_front();
                        want = {1'b1, b, 1'b0};
                        check(got === want, "frame_bits", 32'(got), 32'(want));
                    end
                    check(stable, "bit_period", 32'(stable), 1);
                    check(!rd_seen, "rd_in_frame", 32'(rd_seen), 0);
                    check(!busy_low, "busy_in_frame", 32'(busy_low), 0);
                    frames_done++;
                    @(negedge clk);
                    if (!rst) begin
                        check(busy === 1'b0, "busy_fall", 32'(busy), 0);
                        check(txd === 1'b1, "stop_end", 32'(txd), 1);
                        gap = 1;
                    end else begin
                        gap = 1000;
                    end
                end
            end
        end
    end

    // Read-strobe protocol and idle-line rules
    initial begin : proto
        logic prev_rd;
        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rd = 1'b0;
            end else begin
                if (fifo_r_enable) begin
                    rd_pulses++;
                    check(fifo_count != 0, "rd_nonempty", 32'(fifo_count), 1);
                    check(!prev_rd, "rd_single", 32'(prev_rd), 0);
                end
                if (!busy) check(txd === 1'b1 && fifo_r_enable === 1'b0, "idle_line",
                                 32'({txd, fifo_r_enable}), 32'b10);
                prev_rd = fifo_r_enable;
            end
        end
    end

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        writes++;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic send_with_latency(input logic [7:0] b);
        write_byte(b);
        check(fifo_r_enable === 1'b0, "lat_e0_rd", 32'(fifo_r_enable), 0);
        @(negedge clk);
        check(fifo_r_enable === 1'b1 && busy === 1'b1, "lat_e1_fetch", 32'({fifo_r_enable, busy}), 32'b11);
        @(negedge clk);
        check(fifo_r_enable === 1'b0 && txd === 1'b1, "lat_e2_load", 32'({fifo_r_enable, txd}), 32'b01);
        @(negedge clk);
        check(txd === 1'b0, "lat_e3_start", 32'(txd), 0);
    endtask

    task automatic wait_fall(input int budget);
        int n = 0;
        while (txd !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(txd === 1'b0, "start_timeout", 32'(n), 32'(budget));
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(frames_done >= target, "frame_timeout", 32'(frames_done), 32'(target));
    endtask

    initial begin : stim
        int bad, p0, n;
        logic [9:0] frame2;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check(txd === 1'b1 && txd2 === 1'b1, "reset_txd", 32'({txd, txd2}), 32'b11);
        check(fifo_r_enable === 1'b0, "reset_rd", 32'(fifo_r_enable), 0);
        check(busy === 1'b0, "reset_busy", 32'(busy), 0);
        rst = 1'b0;

        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (txd !== 1'b1 || fifo_r_enable !== 1'b0 || busy !== 1'b0) bad++;
        end
        check(bad == 0, "idle_empty", 32'(bad), 0);

        send_with_latency(8'hA5);
        wait_frames(1, 100);

        p0 = rd_pulses;
        write_byte(8'h00);
        write_byte(8'hFF);
        wait_frames(3, 200);
        check(last_gap == 3, "b2b_gap", 32'(last_gap), 3);
        repeat (30) @(negedge clk);
        check(rd_pulses - p0 == 2, "b2b_pulses", 32'(rd_pulses - p0), 2);

        write_byte(8'h3C);
        wait_fall(20);
        repeat (2 * C + 2) @(negedge clk);
        write_byte(8'h81);
        wait_frames(5, 300);
        repeat (10) @(negedge clk);

        write_byte(8'hF0);
        wait_fall(20);
        repeat (4 * C + 1) @(negedge clk);
        check(txd === 1'b0, "pre_rst_bit3", 32'(txd), 0);
        #1 rst = 1'b1;
        #1;
        check(txd === 1'b1, "rst_async_txd", 32'(txd), 1);
        check(busy === 1'b0 && fifo_r_enable === 1'b0, "rst_async_ctl", 32'({busy, fifo_r_enable}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (txd !== 1'b1 || fifo_r_enable !== 1'b0 || busy !== 1'b0) bad++;
        end
        check(bad == 0, "post_rst_idle", 32'(bad), 0);
        send_with_latency(8'h5A);
        wait_frames(6, 100);

        b2  = 8'h55;
        wr2 = 1'b1;
        @(negedge clk);
        wr2 = 1'b0;
        n = 0;
        while (txd2 !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(txd2 === 1'b0, "min_start_timeout", 32'(n), 20);
        frame2 = {1'b1, b2, 1'b0};
        bad = 0;
        for (int i = 0; i < 10 * C2; i++) begin
            if (i > 0) @(negedge clk);
            if (txd2 !== frame2[i / C2]) bad++;
        end
        check(bad == 0, "min_frame_bits", 32'(bad), 0);
        @(negedge clk);
        check(txd2 === 1'b1 && busy2 === 1'b0, "min_frame_len", 32'({txd2, busy2}), 32'b10);

        for (int i = 0; i < 25; i++) begin
            write_byte(8'($urandom));
            if ($urandom_range(0, 3) != 0) repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(exp_q.size() == 0, "drain", 32'(exp_q.size()), 0);
        repeat (10) @(negedge clk);
        check(rd_pulses == writes, "rd_total", 32'(rd_pulses), 32'(writes));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
